// File: rtl/bp_update_if.sv
// Bundle between Execute (resolution source), the predictor table write port
// and bp_update_ctrl.
//
// Handshake: upd_valid_i is a one-cycle strobe with no ready. The producer
// never stalls on it. full_o is a level indication of a full resolution FIFO
// that Execute may use to stall. An update presented while the FIFO is full
// and nothing drains that cycle is discarded and counted. tbl_we_o is a
// one-cycle write strobe. The table RAM must take the write on the cycle it is
// asserted, so there is no back-pressure from the table side either.
interface bp_update_if #(
  parameter int IDX_W = 5,
  parameter int TAG_W = 8
);
  logic              upd_valid_i;
  logic [31:0]       upd_pc_i;
  logic              upd_taken_i;
  logic              upd_isjump_i;
  logic [31:0]       upd_target_i;
  logic              full_o;

  logic              tbl_we_o;
  logic [IDX_W-1:0]  tbl_idx_o;
  logic [TAG_W-1:0]  tbl_tag_o;
  logic              tbl_valid_o;
  logic              tbl_taken_o;
  logic              tbl_jump_o;
  logic [31:0]       tbl_target_o;

  // Environment side: Execute drives updates, the table RAM consumes writes.
  modport master (
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_isjump_i, upd_target_i,
    input  full_o,
    input  tbl_we_o, tbl_idx_o, tbl_tag_o, tbl_valid_o, tbl_taken_o,
           tbl_jump_o, tbl_target_o
  );

  // Controller side.
  modport slave (
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_isjump_i, upd_target_i,
    output full_o,
    output tbl_we_o, tbl_idx_o, tbl_tag_o, tbl_valid_o, tbl_taken_o,
           tbl_jump_o, tbl_target_o
  );
endinterface

// File: rtl/bp_update_ctrl.sv
// Branch predictor table write sequencer. An init walk clears every entry
// after reset or flush. Resolutions from Execute are then buffered in a small
// FIFO and written back in arrival order, one write per cycle.
module bp_update_ctrl #(
  parameter int NUM_ENTRIES = 32,
  parameter int IDX_W       = 5,
  parameter int TAG_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  bp_update_if.slave        bus,
  output logic              init_done_o,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic              dbg_state_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic             jump;
    logic [31:0]      target;
  } entry_t;

  entry_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [FCNT_W-1:0]   fifo_cnt;
  logic [IDX_W-1:0]    init_idx;
  state_t              state;
  logic [CNT_W-1:0]    drop_cnt;

  logic                tbl_we;
  logic [IDX_W-1:0]    tbl_idx;
  logic [TAG_W-1:0]    tbl_tag;
  logic                tbl_valid;
  logic                tbl_taken;
  logic                tbl_jump;
  logic [31:0]         tbl_target;

  logic                fifo_full;
  logic                pop;
  logic                push;
  logic                drop;
  entry_t              push_entry;
  entry_t              head;
  logic                unused_pc_bits;

  // Index/tag slicing of the resolved PC and the FIFO accept/drain decisions.
  // A flush discards the push of its own cycle without counting it as a drop.
  always_comb begin
    push_entry.idx    = bus.upd_pc_i[IDX_W+1:2];
    push_entry.tag    = bus.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    push_entry.taken  = bus.upd_taken_i;
    push_entry.jump   = bus.upd_isjump_i;
    push_entry.target = bus.upd_target_i;
    fifo_full = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    pop  = !flush_i && (state == ST_RUN) && (fifo_cnt != '0);
    push = !flush_i && bus.upd_valid_i && (!fifo_full || pop);
    drop = !flush_i && bus.upd_valid_i && fifo_full && !pop;
    head = fifo_mem[rd_ptr];
  end

  assign unused_pc_bits = ^{bus.upd_pc_i[1:0], bus.upd_pc_i[31:IDX_W+TAG_W+2]};

  // FIFO storage. Contents are meaningless outside the count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Saturating count of updates lost to a full FIFO. Survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Init-walk / run FSM with registered table write port.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      state       <= ST_INIT;
      init_idx    <= '0;
      init_done_o <= 1'b0;
      tbl_we      <= 1'b0;
      tbl_idx     <= '0;
      tbl_tag     <= '0;
      tbl_valid   <= 1'b0;
      tbl_taken   <= 1'b0;
      tbl_jump    <= 1'b0;
      tbl_target  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          tbl_we     <= 1'b1;
          tbl_idx    <= init_idx;
          tbl_tag    <= '0;
          tbl_valid  <= 1'b0;
          tbl_taken  <= 1'b0;
          tbl_jump   <= 1'b0;
          tbl_target <= '0;
          init_idx   <= init_idx + 1'b1;
          if (init_idx == IDX_W'(NUM_ENTRIES - 1)) begin
            state       <= ST_RUN;
            init_done_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (pop) begin
            tbl_we     <= 1'b1;
            tbl_idx    <= head.idx;
            tbl_tag    <= head.tag;
            tbl_valid  <= 1'b1;
            tbl_taken  <= head.taken;
            tbl_jump   <= head.jump;
            tbl_target <= head.target;
          end else begin
            tbl_we <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.full_o       = fifo_full;
  assign bus.tbl_we_o     = tbl_we;
  assign bus.tbl_idx_o    = tbl_idx;
  assign bus.tbl_tag_o    = tbl_tag;
  assign bus.tbl_valid_o  = tbl_valid;
  assign bus.tbl_taken_o  = tbl_taken;
  assign bus.tbl_jump_o   = tbl_jump;
  assign bus.tbl_target_o = tbl_target;
  assign drop_cnt_o       = drop_cnt;
  assign dbg_state_o      = state;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: vector table for single updates plus
// hand-written sequences for init walk, overflow, flush, full-FIFO streaming,
// drop-counter saturation (CNT_W=2 instance) and mid-walk reset.
module tb_bp_update_ctrl;

  localparam int IDX_W = 5;
  localparam int TAG_W = 8;
  localparam int NUM_ENTRIES = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  bp_update_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();
  bp_update_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus2 ();

  logic        init_done, init_done2_unused;
  logic [15:0] drop_cnt;
  logic [1:0]  drop_cnt2;
  logic        dbg_state_unused, dbg_state2_unused;

  bp_update_ctrl #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W),
                   .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush_i(flush), .bus(bus),
    .init_done_o(init_done), .drop_cnt_o(drop_cnt), .dbg_state_o(dbg_state_unused)
  );

  bp_update_ctrl #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W),
                   .FIFO_DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .flush_i(flush), .bus(bus2),
    .init_done_o(init_done2_unused), .drop_cnt_o(drop_cnt2), .dbg_state_o(dbg_state2_unused)
  );

  assign bus2.upd_valid_i  = bus.upd_valid_i;
  assign bus2.upd_pc_i     = bus.upd_pc_i;
  assign bus2.upd_taken_i  = bus.upd_taken_i;
  assign bus2.upd_isjump_i = bus.upd_isjump_i;
  assign bus2.upd_target_i = bus.upd_target_i;

  // ---------------- scoreboard ----------------
  logic [47:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        jump;
    logic [31:0] target;
    logic [4:0]  exp_idx;
    logic [7:0]  exp_tag;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] wr_word(input logic [4:0] idx, input logic [7:0] tag,
                                          input logic valid, input logic taken,
                                          input logic jump, input logic [31:0] target);
    return {idx, tag, valid, taken, jump, target};
  endfunction

  // One clock: inputs set before the edge, outputs sampled on the falling edge;
  // every table write seen is compared against the head of exp_q.
  task automatic tick();
    logic [47:0] act;
    logic [47:0] e;
    @(posedge clk);
    @(negedge clk);
    if (bus.tbl_we_o) begin
      act = {bus.tbl_idx_o, bus.tbl_tag_o, bus.tbl_valid_o, bus.tbl_taken_o,
             bus.tbl_jump_o, bus.tbl_target_o};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got write 0x%0h expected no write", act);
      end else begin
        e = exp_q.pop_front();
        check("tbl_write", act, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_upd(input logic v, input logic [31:0] pc, input logic taken,
                         input logic jump, input logic [31:0] target);
    bus.upd_valid_i  = v;
    bus.upd_pc_i     = pc;
    bus.upd_taken_i  = taken;
    bus.upd_isjump_i = jump;
    bus.upd_target_i = target;
  endtask

  task automatic set_idle();
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Generic update k: index/tag chosen first, PC built from them.
  function automatic logic [4:0] gen_idx(input int k);
    return 5'((k * 3 + 1) % 32);
  endfunction
  function automatic logic [7:0] gen_tag(input int k);
    return 8'(8'h10 + k);
  endfunction

  task automatic drive_gen(input int k);
    logic [4:0] i5;
    logic [7:0] t8;
    logic [1:0] kb;
    i5 = gen_idx(k);
    t8 = gen_tag(k);
    kb = 2'(k);
    set_upd(1'b1, {17'h0, t8, i5, 2'b00}, kb[0], kb[1], 32'h2000_0000 + 32'(k));
  endtask

  function automatic logic [47:0] gen_word(input int k);
    logic [1:0] kb;
    kb = 2'(k);
    return wr_word(gen_idx(k), gen_tag(k), 1'b1, kb[0], kb[1], 32'h2000_0000 + 32'(k));
  endfunction

  task automatic expect_init_walk(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(wr_word(5'(i), 8'h0, 1'b0, 1'b0, 1'b0, 32'h0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{pc: 32'h0000_0044, taken: 1'b1, jump: 1'b0, target: 32'h0000_0010, exp_idx: 5'd17, exp_tag: 8'h00};
    vecs[1] = '{pc: 32'h0000_1F80, taken: 1'b0, jump: 1'b0, target: 32'h0000_1F00, exp_idx: 5'd0,  exp_tag: 8'h3F};
    vecs[2] = '{pc: 32'hFFFF_FFFC, taken: 1'b1, jump: 1'b1, target: 32'h8000_0000, exp_idx: 5'd31, exp_tag: 8'hFF};
    vecs[3] = '{pc: 32'h0001_2374, taken: 1'b1, jump: 1'b1, target: 32'h1234_5678, exp_idx: 5'd29, exp_tag: 8'h46};
    vecs[4] = '{pc: 32'h0000_0008, taken: 1'b0, jump: 1'b0, target: 32'h0000_0000, exp_idx: 5'd2,  exp_tag: 8'h00};

    set_idle();
    reset = 1'b1;
    tick();
    tick();
    check("reset_we", bus.tbl_we_o, 0);
    check("reset_init_done", init_done, 0);
    check("reset_full", bus.full_o, 0);
    check("reset_drop", drop_cnt, 0);
    check("reset_idx", bus.tbl_idx_o, 0);

    // Power-up init walk: 32 clearing writes, idx 0..31.
    reset = 1'b0;
    expect_init_walk(NUM_ENTRIES);
    for (int i = 1; i <= NUM_ENTRIES; i++) begin
      tick();
      if (i == NUM_ENTRIES - 1) check("init_done_mid_walk", init_done, 0);
    end
    check("init_walk_count", exp_q.size(), 0);
    check("init_done_after_walk", init_done, 1);
    tick();
    check("run_idle_we", bus.tbl_we_o, 0);
    check("run_init_done", init_done, 1);

    // Vector table: single updates in RUN, two-edge latency, one-cycle strobe.
    for (int v = 0; v < 5; v++) begin
      set_upd(1'b1, vecs[v].pc, vecs[v].taken, vecs[v].jump, vecs[v].target);
      tick();
      set_idle();
      check("vec_no_bypass", bus.tbl_we_o, 0);
      exp_q.push_back(wr_word(vecs[v].exp_idx, vecs[v].exp_tag, 1'b1,
                              vecs[v].taken, vecs[v].jump, vecs[v].target));
      tick();
      check("vec_we", bus.tbl_we_o, 1);
      check("vec_written", exp_q.size(), 0);
      tick();
      check("vec_one_cycle", bus.tbl_we_o, 0);
    end

    // Six pushes during INIT: four buffered, two dropped, drained in order.
    flush = 1'b1;
    tick();
    check("flush_we", bus.tbl_we_o, 0);
    check("flush_init_done", init_done, 0);
    flush = 1'b0;
    expect_init_walk(NUM_ENTRIES);
    for (int k = 1; k <= 4; k++) exp_q.push_back(gen_word(k));
    for (int t = 1; t <= 37; t++) begin
      if (t <= 6) drive_gen(t); else set_idle();
      tick();
      if (t == 3) check("ovf_not_full_at_3", bus.full_o, 0);
      if (t == 4) check("ovf_full_at_4", bus.full_o, 1);
      if (t == 6) begin
        check("ovf_full_at_6", bus.full_o, 1);
        check("ovf_drop", drop_cnt, 2);
        check("ovf_drop_sat", drop_cnt2, 2);
      end
    end
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_we_after", bus.tbl_we_o, 0);
    check("ovf_full_after", bus.full_o, 0);

    // Flush with 3 entries queued mid-walk; flush held with a push present.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_init_walk(3);
    for (int k = 11; k <= 13; k++) begin
      drive_gen(k);
      tick();
    end
    flush = 1'b1;
    drive_gen(20);
    for (int h = 0; h < 3; h++) begin
      tick();
      check("flush_hold_we", bus.tbl_we_o, 0);
      check("flush_hold_full", bus.full_o, 0);
      check("flush_hold_drop", drop_cnt, 2);
    end
    flush = 1'b0;
    set_idle();
    expect_init_walk(NUM_ENTRIES);
    for (int t = 1; t <= NUM_ENTRIES + 1; t++) tick();
    check("flush_rewalk", exp_q.size(), 0);
    check("flush_we_after", bus.tbl_we_o, 0);
    check("flush_drop_kept", drop_cnt, 2);
    check("flush_init_done", init_done, 1);

    // Full FIFO in RUN with valid every cycle: push accepted alongside each pop.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_init_walk(NUM_ENTRIES);
    for (int k = 30; k <= 33; k++) exp_q.push_back(gen_word(k));
    for (int k = 40; k <= 47; k++) exp_q.push_back(gen_word(k));
    for (int t = 1; t <= 45; t++) begin
      if (t <= 4) drive_gen(29 + t);
      else if (t >= 33 && t <= 40) drive_gen(40 + t - 33);
      else set_idle();
      tick();
      if (t >= 33 && t <= 40) check("stream_full", bus.full_o, 1);
    end
    check("stream_drained", exp_q.size(), 0);
    check("stream_drop", drop_cnt, 2);
    check("stream_we_after", bus.tbl_we_o, 0);

    // Five more drops: 16-bit counter reaches 7, 2-bit counter saturates at 3.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_init_walk(NUM_ENTRIES);
    for (int k = 50; k <= 53; k++) exp_q.push_back(gen_word(k));
    for (int t = 1; t <= 37; t++) begin
      if (t <= 9) drive_gen(49 + t); else set_idle();
      tick();
      if (t >= 5 && t <= 9) begin
        check("sat_drop_wide", drop_cnt, 64'(2 + t - 4));
        check("sat_drop_narrow", drop_cnt2, 3);
      end
    end
    check("sat_drained", exp_q.size(), 0);
    check("sat_final_wide", drop_cnt, 7);
    check("sat_final_narrow", drop_cnt2, 3);

    // Reset mid-walk with pending entries: everything back to power-up state.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_init_walk(2);
    drive_gen(60);
    tick();
    drive_gen(61);
    tick();
    set_idle();
    reset = 1'b1;
    tick();
    check("mid_reset_we", bus.tbl_we_o, 0);
    check("mid_reset_full", bus.full_o, 0);
    check("mid_reset_drop", drop_cnt, 0);
    check("mid_reset_drop_narrow", drop_cnt2, 0);
    check("mid_reset_init_done", init_done, 0);
    reset = 1'b0;
    expect_init_walk(NUM_ENTRIES);
    for (int t = 1; t <= NUM_ENTRIES + 1; t++) tick();
    check("mid_reset_rewalk", exp_q.size(), 0);
    check("mid_reset_we_after", bus.tbl_we_o, 0);
    check("mid_reset_done_after", init_done, 1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
